// File: rtl/crc_checker.sv
// Receive-side serial CRC checker: recomputes the LFSR CRC over an LSB-first
// message, then compares it bit-by-bit against the received LSB-first CRC.
module crc_checker #(
   parameter int                  DATA_BITS = 8,
   parameter int                  CRC_BITS  = 8,
   parameter logic [CRC_BITS-1:0] SEED      = 8'hD8,
   parameter logic [CRC_BITS-1:0] TAPS      = 8'h44
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_data,
   input  logic i_active,
   input  logic i_crc_valid,
   output logic o_busy,
   output logic o_done,
   output logic o_crc_ok,
   output logic o_crc_err,
   output logic o_frame_err
);

   localparam int MAX_BITS = (DATA_BITS > CRC_BITS) ? DATA_BITS : CRC_BITS;
   localparam int CW       = $clog2(MAX_BITS + 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] CRC_LAST  = CW'(CRC_BITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_CRC    = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   // One LFSR step: feedback enters at the top and is XORed into the tapped bits.
   function automatic logic [CRC_BITS-1:0] lfsr_step(input logic [CRC_BITS-1:0] r,
                                                     input logic              d);
      logic fb;
      fb = d ^ r[0];
      return {fb, r[CRC_BITS-1:1] ^ (TAPS[CRC_BITS-2:0] & {(CRC_BITS-1){fb}})};
   endfunction

   state_t              r_state, w_state_nxt;
   logic [CRC_BITS-1:0] r_lfsr,  w_lfsr_nxt;
   logic [CW-1:0]       r_cnt,   w_cnt_nxt;
   logic                r_mis,   w_mis_nxt;
   logic                r_busy;
   logic                r_done,  w_done_nxt;
   logic                r_ok,    w_ok_nxt;
   logic                r_err,   w_err_nxt;
   logic                r_ferr,  w_ferr_nxt;

   // State, datapath and registered status update.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_lfsr  <= SEED;
         r_cnt   <= '0;
         r_mis   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ok    <= 1'b0;
         r_err   <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_lfsr  <= w_lfsr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mis   <= w_mis_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_done  <= w_done_nxt;
         r_ok    <= w_ok_nxt;
         r_err   <= w_err_nxt;
         r_ferr  <= w_ferr_nxt;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_lfsr_nxt  = r_lfsr;
      w_cnt_nxt   = r_cnt;
      w_mis_nxt   = r_mis;
      w_done_nxt  = 1'b0;
      w_ok_nxt    = r_ok;
      w_err_nxt   = r_err;
      w_ferr_nxt  = r_ferr;

      case (r_state)
         ST_IDLE: begin
            if (i_active) begin
               w_lfsr_nxt = lfsr_step(SEED, i_data);
               w_mis_nxt  = 1'b0;
               w_ok_nxt   = 1'b0;
               w_err_nxt  = 1'b0;
               w_ferr_nxt = 1'b0;
               if (DATA_BITS == 1) begin
                  w_state_nxt = ST_CRC;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = ST_DATA;
                  w_cnt_nxt   = CW'(1);
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end

         ST_DATA: begin
            if (i_crc_valid || !i_active) begin
               w_ferr_nxt  = 1'b1;
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_lfsr_nxt = lfsr_step(r_lfsr, i_data);
               if (r_cnt == DATA_LAST) begin
                  w_state_nxt = ST_CRC;
                  w_cnt_nxt   = '0;
                  w_mis_nxt   = 1'b0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end

         ST_CRC: begin
            if (i_active) begin
               w_ferr_nxt  = 1'b1;
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (i_crc_valid) begin
               // Received CRC is compared LSB first while the register drains.
               w_mis_nxt  = r_mis | (i_data ^ r_lfsr[0]);
               w_lfsr_nxt = r_lfsr >> 1;
               if (r_cnt == CRC_LAST) begin
                  w_state_nxt = ST_REPORT;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end else begin
               w_state_nxt = ST_CRC;
            end
         end

         ST_REPORT: begin
            w_done_nxt  = 1'b1;
            w_ok_nxt    = ~r_mis;
            w_err_nxt   = r_mis;
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_crc_ok    = r_ok;
   assign o_crc_err   = r_err;
   assign o_frame_err = r_ferr;

endmodule

// File: tb/tb_crc_checker.sv
// Directed bench for crc_checker; expected frame results go to a scoreboard
// queue and are checked when DONE pulses.
module tb_crc_checker;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   logic i_data = 1'b0;
   logic i_active = 1'b0;
   logic i_crc_valid = 1'b0;
   logic o_busy, o_done, o_crc_ok, o_crc_err, o_frame_err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int frame_id = 0;

   typedef struct {
      int   id;
      int   cyc;
      logic ok;
      logic err;
      logic ferr;
   } exp_t;
   exp_t sb[$];

   crc_checker dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_data      (i_data),
      .i_active    (i_active),
      .i_crc_valid (i_crc_valid),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_crc_ok    (o_crc_ok),
      .o_crc_err   (o_crc_err),
      .o_frame_err (o_frame_err)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference generator: R_next = (R>>1) ^ (fb ? C4 : 0), seed D8.
   function automatic logic [7:0] gen_crc(input logic [7:0] msg);
      logic [7:0] r;
      r = 8'hD8;
      for (int i = 0; i < 8; i++) begin
         if (msg[i] ^ r[0]) r = (r >> 1) ^ 8'hC4;
         else               r = r >> 1;
      end
      return r;
   endfunction

   // Scoreboard consumer: every DONE must match the oldest expected frame.
   always @(negedge i_clk) begin
      if (o_done) begin
         if (sb.size() == 0) begin
            chk1("unexpected_done", 1'b1, 1'b0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chki($sformatf("f%0d_done_cycle", e.id), cyc, e.cyc);
            chk1($sformatf("f%0d_crc_ok", e.id), o_crc_ok, e.ok);
            chk1($sformatf("f%0d_crc_err", e.id), o_crc_err, e.err);
            chk1($sformatf("f%0d_frame_err", e.id), o_frame_err, e.ferr);
            chk1($sformatf("f%0d_busy_at_done", e.id), o_busy, 1'b0);
         end
      end
   end

   // Apply inputs, let one rising edge sample them, return 1 ns after it.
   task automatic tick(input logic a, input logic v, input logic d);
      i_active = a;
      i_crc_valid = v;
      i_data = d;
      @(posedge i_clk);
      #1;
   endtask

   task automatic push(input int done_cyc, input logic ok, input logic err, input logic ferr);
      exp_t e;
      e.id = frame_id;
      e.cyc = done_cyc;
      e.ok = ok;
      e.err = err;
      e.ferr = ferr;
      sb.push_back(e);
      frame_id++;
   endtask

   // Full frame; optional stall of gap_len cycles after CRC bit index gap_after.
   task automatic send_frame(input logic [7:0] msg, input logic [7:0] crc,
                             input int gap_after, input int gap_len);
      logic good;
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, msg[i]);
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, 1'b1, crc[i]);
         if (i == gap_after) repeat (gap_len) tick(1'b0, 1'b0, 1'b1);
      end
      good = (crc == gen_crc(msg));
      push(cyc + 1, good, ~good, 1'b0);
   endtask

   initial begin
      logic [7:0] m;
      int t0, t1;

      // Reset state.
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      chk1("rst_busy", o_busy, 1'b0);
      chk1("rst_done", o_done, 1'b0);
      chk1("rst_ok", o_crc_ok, 1'b0);
      chk1("rst_err", o_crc_err, 1'b0);
      chk1("rst_ferr", o_frame_err, 1'b0);
      i_rst = 1'b0;
      tick(1'b0, 1'b1, 1'b1);   // CRC_VALID in IDLE is ignored
      chk1("idle_crcv_busy", o_busy, 1'b0);

      // Good frame; ACTIVE during the REPORT cycle must be ignored.
      tick(1'b1, 1'b0, 1'b0);
      chk1("start_busy", o_busy, 1'b1);
      for (int i = 1; i < 8; i++) tick(1'b1, 1'b0, 1'b0);
      m = 8'h14;
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, m[i]);
      t0 = cyc + 1;
      push(t0, 1'b1, 1'b0, 1'b0);
      chk1("last_crc_bit_busy", o_busy, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      chk1("report_active_ignored_busy", o_busy, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      chk1("busy_after_done", o_busy, 1'b0);
      repeat (3) tick(1'b0, 1'b0, 1'b0);
      chk1("sticky_ok_hold", o_crc_ok, 1'b1);

      // CRC bit 2 flipped.
      send_frame(8'h00, 8'h10, -1, 0);
      tick(1'b0, 1'b0, 1'b0);

      // Stall of 3 cycles between CRC bits 4 and 5: same result, 3 cycles later.
      t0 = cyc;
      send_frame(8'h00, 8'h14, 3, 3);
      t1 = cyc;
      chki("gap_frame_length", t1 - t0, 19);
      tick(1'b0, 1'b0, 1'b0);

      // ACTIVE drops after 5 message bits.
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      push(cyc, 1'b0, 1'b0, 1'b1);
      chk1("short_frame_busy", o_busy, 1'b0);
      chk1("short_frame_ferr", o_frame_err, 1'b1);
      tick(1'b1, 1'b0, 1'b0);
      chk1("restart_ferr_cleared", o_frame_err, 1'b0);
      for (int i = 1; i < 8; i++) tick(1'b1, 1'b0, 1'b0);
      m = 8'h14;
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, m[i]);
      push(cyc + 1, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);

      // CRC_VALID during DATA.
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      push(cyc, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);

      // ACTIVE during CRC: abort, no restart.
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      push(cyc, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      chk1("crc_abort_no_restart", o_busy, 1'b0);

      // Reset during CRC bit 3.
      send_frame(8'h00, 8'h14, -1, 0);
      tick(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      i_rst = 1'b1;
      tick(1'b0, 1'b1, 1'b1);
      i_rst = 1'b0;
      chk1("midrst_busy", o_busy, 1'b0);
      chk1("midrst_done", o_done, 1'b0);
      chk1("midrst_ok", o_crc_ok, 1'b0);
      chk1("midrst_err", o_crc_err, 1'b0);
      chk1("midrst_ferr", o_frame_err, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      chk1("midrst_idle", o_busy, 1'b0);
      send_frame(8'h00, 8'h14, -1, 0);
      tick(1'b0, 1'b0, 1'b0);

      // Loopback against the reference generator, plus corrupted messages.
      for (int k = 0; k < 13; k++) begin
         if (k < 10)       m = 8'($urandom_range(0, 255));
         else if (k == 10) m = 8'hFF;
         else if (k == 11) m = 8'hA5;
         else              m = 8'h5A;
         send_frame(m, gen_crc(m), -1, 0);
         tick(1'b0, 1'b0, 1'b0);
      end
      for (int k = 0; k < 4; k++) begin
         logic [7:0] flip;
         m = 8'($urandom_range(0, 255));
         flip = 8'h01 << (2 * k + 1);
         send_frame(m ^ flip, gen_crc(m), -1, 0);
         tick(1'b0, 1'b0, 1'b0);
      end

      repeat (4) tick(1'b0, 1'b0, 1'b0);
      chki("missing_done_count", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/crc_checker.md
Name: crc_checker

Overview:
- Receive-side counterpart of the serial LFSR CRC generator.
- Accepts a serial frame of DATA_BITS message bits, LSB first, qualified by ACTIVE.
- Then accepts CRC_BITS received CRC bits, LSB first, qualified by CRC_VALID.
- Recomputes the CRC with an identical LFSR, compares bit-by-bit and reports pass/fail plus framing errors; sits at the end of the serial link.

Parameters:
DATA_BITS, 8, message bits per frame
CRC_BITS, 8, CRC width (LFSR length)
SEED, 8'hD8, LFSR value loaded at frame start
TAPS, 8'h44, feedback tap mask on bits 0..CRC_BITS-2 (bit 7 unused)

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
DATA  input  1  serial bit; message bit when ACTIVE=1, CRC bit when CRC_VALID=1
ACTIVE  input  1  message-bit qualifier
CRC_VALID  input  1  received-CRC-bit qualifier
BUSY  output  1  frame in progress (state != IDLE)
DONE  output  1  one-cycle pulse, frame result available
CRC_OK  output  1  sticky: last frame CRC matched
CRC_ERR  output  1  sticky: last frame CRC mismatched
FRAME_ERR  output  1  sticky: last frame aborted by protocol violation

Behaviour:
- One clock CLK; RST is synchronous and active-high. While RST=1 at a CLK edge: state=IDLE, LFSR=SEED, counters=0, all outputs 0.
- LFSR step on bit d:
  - fb = d ^ R[0]
  - R_next[CRC_BITS-1] = fb
  - R_next[i] = R[i+1] ^ (TAPS[i] & fb) for i < CRC_BITS-1
  - With the defaults this is R_next = (R>>1) ^ (fb ? 8'hC4 : 0).
- States: IDLE, DATA, CRC, REPORT.
- IDLE:
  - ACTIVE=1: load SEED and step it with DATA in the same cycle; bit count = 1; clear CRC_OK/CRC_ERR/FRAME_ERR; go to DATA.
  - CRC_VALID=1: ignored.
- DATA:
  - Each cycle with ACTIVE=1 steps the LFSR and increments the count.
  - After bit DATA_BITS is consumed, go to CRC (mismatch flag cleared, CRC count = 0).
  - ACTIVE=0 before DATA_BITS bits: FRAME_ERR=1, DONE pulse, go to IDLE.
  - CRC_VALID=1 during DATA: FRAME_ERR=1, DONE pulse, go to IDLE.
- CRC:
  - Each cycle with CRC_VALID=1: compare DATA with R[0], OR any difference into the mismatch flag, shift R right with zero fill (no feedback), increment the CRC count.
  - CRC_VALID=0 stalls with no state change; gaps are unlimited.
  - ACTIVE=1 during CRC: FRAME_ERR=1, DONE pulse, go to IDLE. The frame is not restarted that cycle.
  - After bit CRC_BITS, go to REPORT.
- REPORT (one cycle):
  - DONE=1.
  - CRC_OK = ~mismatch, CRC_ERR = mismatch, both registered.
  - Go to IDLE.
  - DONE rises exactly one cycle after the last CRC bit is sampled.
- Exactly one of CRC_OK/CRC_ERR/FRAME_ERR is set after any DONE. Status holds until the next frame start or RST.
- Back-to-back frames: ACTIVE in the REPORT cycle is ignored. A frame may start on the first cycle back in IDLE.
- RST mid-frame: immediate return to IDLE, no DONE, all status cleared.
- Counters are sized clog2(max(DATA_BITS, CRC_BITS)+1).

Test Plan:
- SEED=8'hD8, message 8'h00, then CRC bits of 8'h14 (0,0,1,0,1,0,0,0) -> DONE pulse 1 cycle after the 8th CRC bit, CRC_OK=1, CRC_ERR=0, FRAME_ERR=0, BUSY low the cycle after DONE.
- Same frame with CRC bit 2 flipped (CRC 8'h10) -> DONE, CRC_ERR=1, CRC_OK=0.
- Message 8'h00, CRC 8'h14 with CRC_VALID low for 3 cycles between bits 4 and 5 -> result identical to the first case, DONE delayed by 3 cycles.
- ACTIVE drops after 5 message bits -> DONE pulse next edge, FRAME_ERR=1, state IDLE. A following valid frame then yields CRC_OK=1 with FRAME_ERR cleared at its start.
- RST asserted during CRC bit 3 -> all outputs 0 next cycle, no DONE. A new full frame then checks correctly.
- Loopback against the generator for 10 random bytes plus 8'hFF, 8'hA5, 8'h5A -> CRC_OK=1 on every frame. Single-bit message corruption -> CRC_ERR=1.
